// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer.
//   trace_kind_t : record kind (SKIP / REG / HILO)
//   trace_rec_t  : packed trace record with the default 32-bit commit stamp
package commit_trace_buffer_pkg;

  localparam int unsigned TraceCntW = 32;

  typedef enum logic [1:0] {
    TRACE_SKIP = 2'd0,
    TRACE_REG  = 2'd1,
    TRACE_HILO = 2'd2
  } trace_kind_t;

  typedef struct packed {
    trace_kind_t            kind;
    logic [TraceCntW-1:0]   cycle;
    logic [4:0]             addr;
    logic [31:0]            data0;
    logic [31:0]            data1;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO of trace records.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless popping in the same cycle)
//   pop        : consume head (ignored when empty)
//   head       : current head record (undefined contents while empty)
//   empty/full : occupancy flags
//   level      : occupancy, 0..DEPTH
module trace_fifo
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type rec_t = trace_rec_t,
  localparam int unsigned AddrW = $clog2(DEPTH),
  localparam int unsigned LvlW = AddrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  rec_t            push_data,
  input  logic            pop,
  output rec_t            head,
  output logic            empty,
  output logic            full,
  output logic [LvlW-1:0] level
);

  rec_t             mem [DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == LvlW'(DEPTH));
  assign level = count_q;
  assign head  = mem[rptr_q];

  // When full, a simultaneous pop frees the slot the write lands in.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AddrW'(1);
    if (pop_ok)  rptr_d = rptr_q + AddrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: samples committed GPR and HI/LO writes, stamps each with
// the enabled-cycle count and queues the records for a valid/ready consumer.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   trace_en                      : capture enable (low clears the stamp counter)
//   reg_we/reg_waddr/reg_wdata    : GPR writeback
//   hilo_we/hi_i/lo_i             : HI/LO writeback
//   rec_valid/rec_ready           : drain handshake
//   rec_kind/rec_cycle/rec_addr/rec_data0/rec_data1 : head record (zero when empty)
//   level                         : FIFO occupancy
//   overflow/clear_overflow       : sticky drop flag and its clear
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned RECORD_SKIP = 1,
  localparam int unsigned LvlW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trace_en,
  input  logic             reg_we,
  input  logic [4:0]       reg_waddr,
  input  logic [31:0]      reg_wdata,
  input  logic             hilo_we,
  input  logic [31:0]      hi_i,
  input  logic [31:0]      lo_i,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_kind,
  output logic [CNT_W-1:0] rec_cycle,
  output logic [4:0]       rec_addr,
  output logic [31:0]      rec_data0,
  output logic [31:0]      rec_data1,
  output logic [LvlW-1:0]  level,
  output logic             overflow,
  input  logic             clear_overflow
);

  typedef struct packed {
    trace_kind_t       kind;
    logic [CNT_W-1:0]  cycle;
    logic [4:0]        addr;
    logic [31:0]       data0;
    logic [31:0]       data1;
  } rec_t;

  localparam logic SkipEn = (RECORD_SKIP != 0);

  logic [CNT_W-1:0] stamp_q, stamp_d;
  logic             overflow_q, overflow_d;
  rec_t             new_rec;
  rec_t             head;
  rec_t             head_out;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;

  // stamp_q counts enabled cycles already completed, so the current one is +1.
  always_comb begin
    new_rec       = '0;
    new_rec.kind  = TRACE_SKIP;
    new_rec.cycle = stamp_q + CNT_W'(1);
    if (reg_we) begin
      new_rec.kind  = TRACE_REG;
      new_rec.addr  = reg_waddr;
      new_rec.data0 = reg_wdata;
    end else if (hilo_we) begin
      new_rec.kind  = TRACE_HILO;
      new_rec.data0 = hi_i;
      new_rec.data1 = lo_i;
    end
  end

  assign push = trace_en & (reg_we | hilo_we | SkipEn);
  assign pop  = rec_valid & rec_ready;

  always_comb begin
    stamp_d    = trace_en ? stamp_q + CNT_W'(1) : '0;
    // A drop sets the flag even when a clear arrives in the same cycle.
    overflow_d = (push & full & ~pop) | (overflow_q & ~clear_overflow);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stamp_q    <= stamp_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (new_rec),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .level     (level)
  );

  // Present an all-zero record while empty so stale storage never leaks out.
  assign head_out  = empty ? '0 : head;
  assign rec_valid = ~empty;
  assign rec_kind  = head_out.kind;
  assign rec_cycle = head_out.cycle;
  assign rec_addr  = head_out.addr;
  assign rec_data0 = head_out.data0;
  assign rec_data1 = head_out.data1;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en, reg_we, hilo_we, rec_ready, clear_overflow;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata, hi_i, lo_i;
  logic        rec_valid, overflow;
  logic [1:0]  rec_kind;
  logic [31:0] rec_cycle, rec_data0, rec_data1;
  logic [4:0]  rec_addr;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .DEPTH       (16),
    .CNT_W       (32),
    .RECORD_SKIP (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trace_en       (trace_en),
    .reg_we         (reg_we),
    .reg_waddr      (reg_waddr),
    .reg_wdata      (reg_wdata),
    .hilo_we        (hilo_we),
    .hi_i           (hi_i),
    .lo_i           (lo_i),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_kind       (rec_kind),
    .rec_cycle      (rec_cycle),
    .rec_addr       (rec_addr),
    .rec_data0      (rec_data0),
    .rec_data1      (rec_data1),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  typedef struct {
    logic        en;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_kind;
    logic [31:0] e_cycle;
    logic [4:0]  e_addr;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [4:0]  e_level;
  } vec_t;

  localparam logic [1:0] KSkip = 2'd0;
  localparam logic [1:0] KReg  = 2'd1;
  localparam logic [1:0] KHilo = 2'd2;

  vec_t vecs [15];

  function automatic vec_t mk(input logic en, we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic hwe,
                              input logic [31:0] hi, lo, input logic rdy,
                              input logic e_valid, input logic [1:0] e_kind,
                              input logic [31:0] e_cycle, input logic [4:0] e_addr,
                              input logic [31:0] e_d0, e_d1, input logic [4:0] e_level);
    vec_t v;
    v.en = en; v.we = we; v.waddr = waddr; v.wdata = wdata; v.hwe = hwe;
    v.hi = hi; v.lo = lo; v.rdy = rdy; v.e_valid = e_valid; v.e_kind = e_kind;
    v.e_cycle = e_cycle; v.e_addr = e_addr; v.e_d0 = e_d0; v.e_d1 = e_d1;
    v.e_level = e_level;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, we, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic hwe,
                        input logic [31:0] hi, lo, input logic rdy);
    trace_en = en; reg_we = we; reg_waddr = waddr; reg_wdata = wdata;
    hilo_we = hwe; hi_i = hi; lo_i = lo; rec_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_overflow = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    //            en we addr wdata         hwe hi            lo            rdy  val kind   cyc addr d0            d1            lvl
    vecs[0]  = mk(1, 1, 3, 32'h0000_1234, 0, 0,            0,            1,   1, KReg,  1, 3, 32'h0000_1234, 0,            1);
    vecs[1]  = mk(1, 1, 5, 32'hFFFF_0000, 1, 32'h1,        32'h2,        0,   1, KReg,  1, 3, 32'h0000_1234, 0,            2);
    vecs[2]  = mk(1, 0, 0, 0,             0, 0,            0,            1,   1, KReg,  2, 5, 32'hFFFF_0000, 0,            2);
    vecs[3]  = mk(0, 0, 0, 0,             0, 0,            0,            1,   1, KSkip, 3, 0, 0,             0,            1);
    vecs[4]  = mk(0, 0, 0, 0,             0, 0,            0,            1,   0, KSkip, 0, 0, 0,             0,            0);
    vecs[5]  = mk(1, 0, 0, 0,             0, 0,            0,            0,   1, KSkip, 1, 0, 0,             0,            1);
    vecs[6]  = mk(1, 0, 0, 0,             0, 0,            0,            0,   1, KSkip, 1, 0, 0,             0,            2);
    vecs[7]  = mk(1, 0, 0, 0,             0, 0,            0,            0,   1, KSkip, 1, 0, 0,             0,            3);
    vecs[8]  = mk(1, 0, 0, 0,             1, 32'hDEADBEEF, 32'h0000CAFE, 0,   1, KSkip, 1, 0, 0,             0,            4);
    vecs[9]  = mk(0, 0, 0, 0,             0, 0,            0,            1,   1, KSkip, 2, 0, 0,             0,            3);
    vecs[10] = mk(0, 0, 0, 0,             0, 0,            0,            1,   1, KSkip, 3, 0, 0,             0,            2);
    vecs[11] = mk(0, 0, 0, 0,             0, 0,            0,            1,   1, KHilo, 4, 0, 32'hDEADBEEF, 32'h0000CAFE, 1);
    vecs[12] = mk(0, 0, 0, 0,             0, 0,            0,            1,   0, KSkip, 0, 0, 0,             0,            0);
    vecs[13] = mk(1, 1, 0, 32'h0000_A5A5, 0, 0,            0,            0,   1, KReg,  1, 0, 32'h0000_A5A5, 0,            1);
    vecs[14] = mk(0, 0, 0, 0,             0, 0,            0,            1,   0, KSkip, 0, 0, 0,             0,            0);

    // Reset state
    tick(); tick();
    check("reset_valid", 64'(rec_valid), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_fields", {rec_kind, rec_cycle, rec_addr}, 64'd0);
    check("reset_data", {rec_data0, rec_data1}, 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].en, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].hwe,
             vecs[i].hi, vecs[i].lo, vecs[i].rdy);
      tick();
      check($sformatf("v%0d_valid", i), 64'(rec_valid), 64'(vecs[i].e_valid));
      check($sformatf("v%0d_kind", i), 64'(rec_kind), 64'(vecs[i].e_kind));
      check($sformatf("v%0d_cycle", i), 64'(rec_cycle), 64'(vecs[i].e_cycle));
      check($sformatf("v%0d_addr", i), 64'(rec_addr), 64'(vecs[i].e_addr));
      check($sformatf("v%0d_data0", i), 64'(rec_data0), 64'(vecs[i].e_d0));
      check($sformatf("v%0d_data1", i), 64'(rec_data1), 64'(vecs[i].e_d1));
      check($sformatf("v%0d_level", i), 64'(level), 64'(vecs[i].e_level));
      check($sformatf("v%0d_overflow", i), 64'(overflow), 64'd0);
    end

    // Overflow: DEPTH+2 writes with no drain, then a drop coinciding with a clear.
    for (int i = 0; i < 18; i++) begin
      set_in(1, 1, 5'(i), 32'h100 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    set_in(1, 1, 5'd31, 32'h1FF, 0, 0, 0, 0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_set_wins", 64'(overflow), 64'd1);
    check("ovf_level_hold", 64'(level), 64'd16);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf_drain%0d_cycle", k), 64'(rec_cycle), 64'(k + 1));
      check($sformatf("ovf_drain%0d_data", k), 64'(rec_data0), 64'(32'h100 + 32'(k)));
      tick();
    end
    check("ovf_drained_level", 64'(level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1, 5'd1, 32'h200 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    check("full_level", 64'(level), 64'd16);
    set_in(1, 1, 5'd2, 32'h2FF, 0, 0, 0, 1);
    tick();
    check("pushpop_level", 64'(level), 64'd16);
    check("pushpop_overflow", 64'(overflow), 64'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("pp_drain%0d_cycle", k), 64'(rec_cycle), 64'(k + 2));
      check($sformatf("pp_drain%0d_data", k), 64'(rec_data0),
            (k == 15) ? 64'h2FF : 64'(32'h201 + 32'(k)));
      tick();
    end
    check("pp_empty", 64'(rec_valid), 64'd0);

    // Asynchronous reset mid-cycle with 7 entries queued.
    for (int i = 0; i < 7; i++) begin
      set_in(1, 1, 5'd4, 32'h300 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    check("prerst_level", 64'(level), 64'd7);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(rec_valid), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_data", 64'(rec_data0), 64'd0);
    #2;
    rst = 1'b1;
    set_in(1, 1, 5'd9, 32'h0000_0909, 0, 0, 0, 0);
    tick();
    check("postrst_cycle", 64'(rec_cycle), 64'd1);
    check("postrst_addr", 64'(rec_addr), 64'd9);
    check("postrst_level", 64'(level), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU writeback stage.
- Samples every committed GPR write and HI/LO write, tags each with a commit-cycle stamp, and buffers the records in a FIFO.
- A valid/ready drain port lets a bench checker or debug UART consume the records at its own pace.
- Replaces per-cycle negedge sampling with a lossless, back-pressured record stream.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- CNT_W, 32, width of the cycle stamp.
- RECORD_SKIP, 1, 1 = also emit a SKIP record on enabled cycles with no write; 0 = suppress them.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted = 0).
- trace_en  in  1  capture enable; low = idle and stamp counter cleared.
- reg_we  in  1  GPR writeback enable.
- reg_waddr  in  5  GPR writeback address.
- reg_wdata  in  32  GPR writeback data.
- hilo_we  in  1  HI/LO write enable.
- hi_i  in  32  HI value being written.
- lo_i  in  32  LO value being written.
- rec_valid  out  1  a record is available at the head of the FIFO.
- rec_ready  in  1  consumer accepts the head record.
- rec_kind  out  2  record kind: 0 SKIP, 1 REG, 2 HILO.
- rec_cycle  out  CNT_W  commit-cycle stamp.
- rec_addr  out  5  GPR address (REG); 0 otherwise.
- rec_data0  out  32  reg_wdata (REG) or HI (HILO); 0 for SKIP.
- rec_data1  out  32  LO (HILO); 0 otherwise.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one record was dropped.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FIFO is emptied; level = 0.
  - rec_valid = 0; rec_kind/rec_cycle/rec_addr/rec_data0/rec_data1 = 0.
  - overflow = 0; stamp counter = 0.
  - Reset mid-drain discards all entries immediately, with no partial record.
- Stamp counter:
  - While trace_en = 1, increments by 1 every cycle and wraps modulo 2^CNT_W.
  - While trace_en = 0, it is held at 0.
  - The first enabled cycle carries stamp 1, so stamp N = Nth enabled cycle.
- Classification, per enabled cycle, evaluated combinationally:
  - reg_we = 1 → REG. REG takes priority even if hilo_we = 1 in the same cycle; the HILO event is not recorded.
  - else hilo_we = 1 → HILO.
  - else SKIP, pushed only if RECORD_SKIP = 1.
  - reg_waddr = 0 writes are recorded as-is; no filtering.
- Push: the record is written at the rising edge that ends the enabled cycle.
- Latency: an event in cycle N appears at the FIFO head (rec_valid = 1 if the FIFO was empty) in cycle N+1.
- FIFO is first-word-fall-through:
  - rec_valid = !empty.
  - Pop occurs on rec_valid & rec_ready.
  - Head fields are stable while rec_valid & !rec_ready.
- Boundary cases:
  - Full with push and no pop: record dropped, overflow set to 1, level stays DEPTH.
  - Full with push and pop in the same cycle: push accepted, level stays DEPTH, no overflow.
  - Empty with push and rec_ready = 1: no bypass; the record appears next cycle.
  - clear_overflow and a new drop in the same cycle: overflow stays 1 (set wins).
  - Pointers wrap modulo DEPTH.
  - trace_en falling: no further pushes; records already queued remain drainable.
- No further state machine: control is push/pop/full/empty plus the sticky flag.

Decomposition:
- cpu_defines.svh gains:
  - trace_kind_t (2-bit enum TRACE_SKIP / TRACE_REG / TRACE_HILO).
  - A packed trace_rec_t struct {kind, cycle, addr, data0, data1}.
- One natural sub-module: trace_fifo, a generic FWFT synchronous FIFO of trace_rec_t.
  - Parameters: DEPTH.
  - Ports: clk, rst (async active-low), push, push_data, pop, head, empty, full, level.
- commit_trace_buffer holds the stamp counter, classifier and overflow flag.

Test Plan:
- Reset, then trace_en = 1; reg_we = 1, reg_waddr = 3, reg_wdata = 0x00001234 in the first enabled cycle; rec_ready = 1 → next cycle rec_valid = 1, kind = REG, cycle = 1, addr = 3, data0 = 0x00001234.
- Same cycle reg_we = 1 ($5 = 0xFFFF0000) and hilo_we = 1 (hi = 0x1, lo = 0x2) → exactly one REG record, addr = 5; no HILO record; level increments by 1.
- RECORD_SKIP = 1, rec_ready = 0, 3 idle enabled cycles then hilo_we with hi = 0xDEADBEEF, lo = 0x0000CAFE → level = 4; drained order: SKIP c1, SKIP c2, SKIP c3, HILO c4 with data0 = 0xDEADBEEF, data1 = 0x0000CAFE.
- rec_ready = 0, DEPTH+2 REG writes → level = 16, overflow = 1; drained stamps 1..16; clear_overflow → overflow = 0.
- Full FIFO, one push with rec_ready = 1 in the same cycle → level stays 16, overflow stays 0, new record last in order.
- Assert rst = 0 mid-cycle with level = 7 → rec_valid and level = 0 immediately, before the next clock edge; after release, the first enabled event gets stamp 1.
